core_mdu_sequencer: RTL and testbench

CORE_MDU_SEQUENCER -- requirements
Module: core_mdu_sequencer

---
 rtl/core_mdu_sequencer.sv | 151 +++++++++++++++
 tb/tb_core_mdu_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mdu_sequencer.sv
// Request/response sequencer for a multi-cycle multiply/divide unit.
// Handles divide-by-zero locally, bounds MDU wait with a timeout, and flushes the MDU after each use.
module core_mdu_sequencer #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 200
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd,
  output logic            rsp_err,
  output logic            mdu_valid,
  output logic            mdu_flush,
  output logic            mdu_op_mul,
  output logic            mdu_op_mulh,
  output logic            mdu_op_mulhsu,
  output logic            mdu_op_mulhu,
  output logic            mdu_op_div,
  output logic            mdu_op_divu,
  output logic            mdu_op_rem,
  output logic            mdu_op_remu,
  output logic            mdu_op_word,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  input  logic            mdu_ready,
  input  logic [XLEN-1:0] mdu_rd
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              word_q;
  logic              fast_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              div_zero;
  logic              fast_path;
  logic              timeout_hit;

  // Divide-by-zero result: quotient is all ones, remainder is the dividend.
  function automatic logic [XLEN-1:0] fast_result(input logic [2:0] op, input logic word,
                                                  input logic [XLEN-1:0] rs1);
    if (!op[1])
      return '1;
    else if (word)
      return {{(XLEN-32){rs1[31]}}, rs1[31:0]};
    else
      return rs1;
  endfunction

  assign accept      = req_valid && req_ready;
  assign div_zero    = req_word ? (req_rs2[31:0] == 32'd0) : (req_rs2 == '0);
  assign fast_path   = req_op[2] && div_zero;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = fast_path ? DONE : RUN;
      RUN:   if (flush) state_nxt = CLEAR;
             else if (mdu_ready || timeout_hit) state_nxt = DONE;
      DONE:  if (flush) state_nxt = CLEAR;
             else if (rsp_ready) state_nxt = fast_q ? IDLE : CLEAR;
      CLEAR: state_nxt = flush ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is also gated by reset so it reads 0 while reset is held.
  always_comb begin
    req_ready     = (state == IDLE) && !flush && g_resetn;
    rsp_valid     = (state == DONE);
    mdu_valid     = (state == RUN);
    mdu_flush     = flush || (state == CLEAR);
    mdu_op_mul    = 1'b0;
    mdu_op_mulh   = 1'b0;
    mdu_op_mulhsu = 1'b0;
    mdu_op_mulhu  = 1'b0;
    mdu_op_div    = 1'b0;
    mdu_op_divu   = 1'b0;
    mdu_op_rem    = 1'b0;
    mdu_op_remu   = 1'b0;
    mdu_op_word   = 1'b0;
    if (state == RUN) begin
      mdu_op_word = word_q;
      case (op_q)
        3'd0: mdu_op_mul    = 1'b1;
        3'd1: mdu_op_mulh   = 1'b1;
        3'd2: mdu_op_mulhsu = 1'b1;
        3'd3: mdu_op_mulhu  = 1'b1;
        3'd4: mdu_op_div    = 1'b1;
        3'd5: mdu_op_divu   = 1'b1;
        3'd6: mdu_op_rem    = 1'b1;
        default: mdu_op_remu = 1'b1;
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      op_q    <= '0;
      word_q  <= 1'b0;
      fast_q  <= 1'b0;
      mdu_rs1 <= '0;
      mdu_rs2 <= '0;
      cnt     <= '0;
      rsp_rd  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        word_q  <= req_word;
        mdu_rs1 <= req_rs1;
        mdu_rs2 <= req_rs2;
        fast_q  <= fast_path;
        cnt     <= '0;
        if (fast_path) begin
          rsp_rd  <= fast_result(req_op, req_word, req_rs1);
          rsp_err <= 1'b0;
        end
      end
      if (state == RUN) begin
        if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
        if (!flush && mdu_ready) begin
          rsp_rd  <= mdu_rd;
          rsp_err <= 1'b0;
        end else if (!flush && timeout_hit) begin
          rsp_rd  <= '0;
          rsp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mdu_sequencer.sv
// Directed bench for core_mdu_sequencer with a small latency-programmable MDU model.
module tb_core_mdu_sequencer;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rd;
  logic        rsp_err;
  logic        mdu_valid, mdu_flush;
  logic        mdu_op_mul, mdu_op_mulh, mdu_op_mulhsu, mdu_op_mulhu;
  logic        mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu, mdu_op_word;
  logic [63:0] mdu_rs1, mdu_rs2;
  logic        mdu_ready = 1'b0;
  logic [63:0] mdu_rd;

  int          checks = 0;
  int          failures = 0;
  int          mdu_lat = 0;
  int          run_cnt = 0;
  logic        mdu_noise = 1'b0;
  logic [63:0] model_rd = '0;
  logic        saw_mdu_valid = 1'b0;
  logic [7:0]  ops;
  int          lat;

  assign mdu_rd = model_rd;
  assign ops = {mdu_op_remu, mdu_op_rem, mdu_op_divu, mdu_op_div,
                mdu_op_mulhu, mdu_op_mulhsu, mdu_op_mulh, mdu_op_mul};

  core_mdu_sequencer #(.XLEN(64), .TIMEOUT(200)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mdu_valid(mdu_valid), .mdu_flush(mdu_flush),
    .mdu_op_mul(mdu_op_mul), .mdu_op_mulh(mdu_op_mulh), .mdu_op_mulhsu(mdu_op_mulhsu),
    .mdu_op_mulhu(mdu_op_mulhu), .mdu_op_div(mdu_op_div), .mdu_op_divu(mdu_op_divu),
    .mdu_op_rem(mdu_op_rem), .mdu_op_remu(mdu_op_remu), .mdu_op_word(mdu_op_word),
    .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd)
  );

  always #5 g_clk = ~g_clk;

  // MDU model: ready in the mdu_lat-th cycle of mdu_valid (never when mdu_lat is 0).
  always begin
    @(posedge g_clk);
    #1;
    if (mdu_valid) begin
      run_cnt = run_cnt + 1;
      mdu_ready = (mdu_lat != 0) && (run_cnt == mdu_lat);
    end else begin
      run_cnt = 0;
      mdu_ready = mdu_noise;
    end
  end

  always @(posedge g_clk) if (mdu_valid) saw_mdu_valid = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #2;
  endtask

  task automatic accept(input logic [2:0] op, input logic word,
                        input logic [63:0] rs1, input logic [63:0] rs2);
    req_op = op; req_word = word; req_rs1 = rs1; req_rs2 = rs2; req_valid = 1'b1;
    #1;
    check("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int n);
    n = 1;
    while (!rsp_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rd", rsp_rd, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst_mdu_valid", {63'd0, mdu_valid}, 64'd0);
    check("rst_ops", {56'd0, ops}, 64'd0);
    check("rst_mdu_flush", {63'd0, mdu_flush}, 64'd0);
    check("rst_mdu_rs1", mdu_rs1, 64'd0);
    g_resetn = 1'b1;
    #1;
    check("rel_mdu_flush", {63'd0, mdu_flush}, 64'd0);
    check("rel_req_ready", {63'd0, req_ready}, 64'd1);

    // MUL 6*7 with a 17-cycle MDU
    mdu_lat = 17; model_rd = 64'd42;
    accept(3'd0, 1'b0, 64'd6, 64'd7);
    check("mul_ops", {56'd0, ops}, 64'h01);
    check("mul_rs1", mdu_rs1, 64'd6);
    check("mul_rs2", mdu_rs2, 64'd7);
    check("mul_busy_ready", {63'd0, req_ready}, 64'd0);
    wait_rsp(100, lat);
    check("mul_latency", 64'(lat), 64'd18);
    check("mul_rd", rsp_rd, 64'd42);
    check("mul_err", {63'd0, rsp_err}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("mul_clear_flush", {63'd0, mdu_flush}, 64'd1);
    check("mul_clear_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("mul_clear_req_ready", {63'd0, req_ready}, 64'd0);
    tick();
    check("mul_idle_flush", {63'd0, mdu_flush}, 64'd0);
    check("mul_idle_req_ready", {63'd0, req_ready}, 64'd1);

    // DIVUW by zero: fast path, no MDU use, no CLEAR
    saw_mdu_valid = 1'b0;
    accept(3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd0);
    wait_rsp(10, lat);
    check("divuw0_latency", 64'(lat), 64'd1);
    check("divuw0_rd", rsp_rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divuw0_err", {63'd0, rsp_err}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("divuw0_no_flush", {63'd0, mdu_flush}, 64'd0);
    check("divuw0_req_ready", {63'd0, req_ready}, 64'd1);
    check("divuw0_no_mdu", {63'd0, saw_mdu_valid}, 64'd0);

    // REMW by zero: sign-extended low word of rs1
    accept(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'd0);
    wait_rsp(10, lat);
    check("remw0_latency", 64'(lat), 64'd1);
    check("remw0_rd", rsp_rd, 64'hFFFF_FFFF_8000_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // DIVW whose divisor is zero only in the low word
    accept(3'd4, 1'b1, 64'd9, 64'h0000_0001_0000_0000);
    wait_rsp(10, lat);
    check("divw_lo0_latency", 64'(lat), 64'd1);
    check("divw_lo0_rd", rsp_rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divw_lo0_no_mdu", {63'd0, saw_mdu_valid}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // DIV with an MDU that never answers
    mdu_lat = 0; model_rd = 64'hDEAD_BEEF;
    accept(3'd4, 1'b0, 64'd100, 64'd5);
    check("div_ops", {56'd0, ops}, 64'h10);
    wait_rsp(400, lat);
    check("timeout_latency", 64'(lat), 64'd201);
    check("timeout_err", {63'd0, rsp_err}, 64'd1);
    check("timeout_rd", rsp_rd, 64'd0);

    // Hold the response with back-pressure while req_valid and mdu_ready toggle
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0];
      mdu_noise = ~i[0];
      #1;
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_rd", rsp_rd, 64'd0);
      check("hold_rsp_err", {63'd0, rsp_err}, 64'd1);
    end
    req_valid = 1'b0; mdu_noise = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("timeout_clear_flush", {63'd0, mdu_flush}, 64'd1);
    tick();
    check("timeout_idle_ready", {63'd0, req_ready}, 64'd1);

    // Flush on the third RUN cycle of MULHU
    accept(3'd3, 1'b0, 64'd11, 64'd13);
    check("mulhu_ops", {56'd0, ops}, 64'h08);
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("flush_mdu_flush", {63'd0, mdu_flush}, 64'd1);
    check("flush_req_ready", {63'd0, req_ready}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_clear_flush", {63'd0, mdu_flush}, 64'd1);
    check("flush_clear_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    check("flush_idle_ready", {63'd0, req_ready}, 64'd1);
    check("flush_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);

    // Flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0;
    #1;
    check("idle_flush_req_ready", {63'd0, req_ready}, 64'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check("idle_flush_stays_idle", {63'd0, mdu_valid}, 64'd0);
    check("idle_flush_ready_back", {63'd0, req_ready}, 64'd1);

    // Asynchronous reset mid-RUN, then a clean MUL
    mdu_lat = 17; model_rd = 64'd15;
    accept(3'd0, 1'b0, 64'd3, 64'd5);
    tick();
    tick();
    #2;
    g_resetn = 1'b0;
    #1;
    check("arst_mdu_valid", {63'd0, mdu_valid}, 64'd0);
    check("arst_ops", {56'd0, ops}, 64'd0);
    check("arst_mdu_rs1", mdu_rs1, 64'd0);
    check("arst_mdu_rs2", mdu_rs2, 64'd0);
    check("arst_req_ready", {63'd0, req_ready}, 64'd0);
    check("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    g_resetn = 1'b1;
    model_rd = 64'd42;
    #1;
    check("arst_rel_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    accept(3'd0, 1'b0, 64'd6, 64'd7);
    wait_rsp(100, lat);
    check("post_rst_latency", 64'(lat), 64'd18);
    check("post_rst_rd", rsp_rd, 64'd42);
    check("post_rst_err", {63'd0, rsp_err}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rst_clear", {63'd0, mdu_flush}, 64'd1);
    tick();
    check("post_rst_idle", {63'd0, req_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
